pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RV32I pipeline: IF, ID, EX, MEM, WB.
- Decodes register usage of the instruction in ID using the same opcode classes as the immediate decoder.
- Detects load-use hazards, applies taken-branch/jump flushes, and freezes the pipeline across I-cache and D-cache miss handshakes.
- Keeps saturating performance counters.
- Sits beside the stage registers; every pipeline register's enable and clear comes from this block.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/rs_use_decoder.sv | 31 +++
 rtl/sat_counter.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: RV32I opcode classes and hazard sequencer states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    IC_WAIT = 2'd1,
    DC_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/rs_use_decoder.sv
// Decodes which source registers the ID-stage instruction actually reads.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the opcode.
module rs_use_decoder
  import pipe_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       use_rs1,
  output logic       use_rs2
);

  // Opcode class lookup; JAL, LUI, AUIPC and unknown opcodes read no registers.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OP, BRANCH, STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_IMM, LOAD, JALR: begin
        use_rs1 = 1'b1;
      end
      default: begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// Latency: count visible one cycle after the inc cycle.
// Backpressure: none; one increment per cycle at most.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  // Increment on request unless already saturated; reset clears.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes, cache-miss freezes.
// Latency: stall/flush outputs are combinational (zero cycles); state and counters are registered.
// Backpressure: a cache miss freezes every stage until its ready pulse; load-use holds IF/ID for one cycle.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      id_inst,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_br_taken,
  input  logic             ic_miss,
  input  logic             ic_ready,
  input  logic             dc_miss,
  input  logic             dc_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             stall_wb,
  output logic             flush_id,
  output logic             flush_ex,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_icmiss,
  output logic [CNT_W-1:0] cnt_dcmiss,
  output logic [CNT_W-1:0] cnt_ldu,
  output logic [CNT_W-1:0] cnt_flush
);

  state_t state, state_nxt;
  logic   ic_done, ic_done_nxt;
  logic   use_rs1, use_rs2;
  logic   load_use;
  logic   freeze;
  logic   br_flush;
  logic   ldu_bubble;
  logic   unused_inst_bits;

  // Only opcode and rs fields matter here; the rest of the word is decoded elsewhere.
  assign unused_inst_bits = ^{id_inst[31:25], id_inst[14:7]};

  rs_use_decoder u_rs_use (
    .opcode  (id_inst[6:0]),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2)
  );

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((use_rs1 && (ex_rd == id_inst[19:15])) ||
                     (use_rs2 && (ex_rd == id_inst[24:20])));

  // A miss freezes in the detect cycle too, before the wait state is entered.
  assign freeze     = rst_n && ((state != RUN) || ic_miss || dc_miss);
  // Branch outranks load-use: the ID instruction is on the wrong path anyway.
  assign br_flush   = rst_n && !freeze && ex_br_taken;
  assign ldu_bubble = rst_n && !freeze && !ex_br_taken && load_use;

  // Stage enables/clears; reset flushes ID/EX so the pipe restarts empty.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    stall_wb  = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    if (!rst_n) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (freeze) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
      stall_wb  = 1'b1;
    end else if (br_flush) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (ldu_bubble) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      flush_ex = 1'b1;
    end
  end

  // Miss sequencing: D-cache first (older instruction), then any I-cache miss not already filled.
  always_comb begin
    state_nxt   = state;
    ic_done_nxt = ic_done;
    case (state)
      RUN: begin
        if (dc_miss) begin
          state_nxt = DC_WAIT;
        end else if (ic_miss) begin
          state_nxt = IC_WAIT;
        end
      end
      DC_WAIT: begin
        if (ic_ready) begin
          ic_done_nxt = 1'b1;
        end
        if (dc_ready) begin
          // An ic_ready in the same cycle counts as already filled.
          if (!ic_miss || ic_done || ic_ready) begin
            state_nxt = RUN;
          end else begin
            state_nxt = IC_WAIT;
          end
        end
      end
      IC_WAIT: begin
        if (ic_ready) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
    if (state_nxt == RUN) begin
      ic_done_nxt = 1'b0;
    end
  end

  // Sequencer state; reset abandons any outstanding wait.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RUN;
      ic_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      ic_done <= ic_done_nxt;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt_stall (
    .clk (clk), .rst_n (rst_n), .inc (stall_if), .cnt (cnt_stall)
  );

  sat_counter #(.W(CNT_W)) u_cnt_icmiss (
    .clk (clk), .rst_n (rst_n),
    .inc ((state != IC_WAIT) && (state_nxt == IC_WAIT)),
    .cnt (cnt_icmiss)
  );

  sat_counter #(.W(CNT_W)) u_cnt_dcmiss (
    .clk (clk), .rst_n (rst_n),
    .inc ((state == RUN) && (state_nxt == DC_WAIT)),
    .cnt (cnt_dcmiss)
  );

  sat_counter #(.W(CNT_W)) u_cnt_ldu (
    .clk (clk), .rst_n (rst_n), .inc (ldu_bubble), .cnt (cnt_ldu)
  );

  sat_counter #(.W(CNT_W)) u_cnt_flush (
    .clk (clk), .rst_n (rst_n), .inc (br_flush), .cnt (cnt_flush)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for the hazard sequencer; expected stall/flush vectors are queued per cycle.
// Latency: outputs sampled at the falling edge of the cycle they are driven in.
// Backpressure: n/a.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 32;

  // {stall_if, stall_id, stall_ex, stall_mem, stall_wb, flush_id, flush_ex}
  localparam logic [6:0] V_NONE = 7'b00000_00;
  localparam logic [6:0] V_FRZ  = 7'b11111_00;
  localparam logic [6:0] V_LDU  = 7'b11000_01;
  localparam logic [6:0] V_BR   = 7'b00000_11;
  localparam logic [6:0] V_RST  = 7'b00000_11;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      id_inst;
  logic [4:0]       ex_rd;
  logic             ex_mem_read, ex_br_taken;
  logic             ic_miss, ic_ready, dc_miss, dc_ready;
  logic             stall_if, stall_id, stall_ex, stall_mem, stall_wb;
  logic             flush_id, flush_ex;
  logic [CNT_W-1:0] cnt_stall, cnt_icmiss, cnt_dcmiss, cnt_ldu, cnt_flush;

  logic [6:0] exp_q[$];
  string      tag_q[$];
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_inst     (id_inst),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .ex_br_taken (ex_br_taken),
    .ic_miss     (ic_miss),
    .ic_ready    (ic_ready),
    .dc_miss     (dc_miss),
    .dc_ready    (dc_ready),
    .stall_if    (stall_if),
    .stall_id    (stall_id),
    .stall_ex    (stall_ex),
    .stall_mem   (stall_mem),
    .stall_wb    (stall_wb),
    .flush_id    (flush_id),
    .flush_ex    (flush_ex),
    .cnt_stall   (cnt_stall),
    .cnt_icmiss  (cnt_icmiss),
    .cnt_dcmiss  (cnt_dcmiss),
    .cnt_ldu     (cnt_ldu),
    .cnt_flush   (cnt_flush)
  );

  // Queue the expected output vector, compare mid-cycle, then advance one clock.
  task automatic step(input logic [6:0] exp, input string tag);
    logic [6:0] obs;
    logic [6:0] e;
    string      t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    obs = {stall_if, stall_id, stall_ex, stall_mem, stall_wb, flush_id, flush_ex};
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", t, obs, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] e);
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  initial begin
    logic [31:0] add_x5x5;
    logic [31:0] lui_rs5;
    logic [31:0] addi_rs3;
    logic [31:0] sw_rs2_5;
    add_x5x5 = 32'h00528633;
    lui_rs5  = {7'b0, 5'd5, 5'd5, 3'b000, 5'd1, 7'b0110111};
    addi_rs3 = {12'h005, 5'd3, 3'b000, 5'd1, 7'b0010011};
    sw_rs2_5 = {7'b0, 5'd5, 5'd3, 3'b010, 5'd0, 7'b0100011};

    rst_n = 1'b0; id_inst = 32'h00000013; ex_rd = 5'd0;
    ex_mem_read = 1'b0; ex_br_taken = 1'b0;
    ic_miss = 1'b0; ic_ready = 1'b0; dc_miss = 1'b0; dc_ready = 1'b0;

    // Reset: comb outputs and cleared counters.
    step(V_RST, "reset_outputs");
    chk_cnt("reset_cnt_stall", cnt_stall, 0);
    chk_cnt("reset_cnt_ldu", cnt_ldu, 0);
    chk_cnt("reset_cnt_flush", cnt_flush, 0);
    rst_n = 1'b1;
    step(V_NONE, "idle");

    // Load-use on add x12,x5,x5: one bubble, then bubble in EX clears it.
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_inst = add_x5x5;
    step(V_LDU, "ldu_bubble");
    ex_mem_read = 1'b0;
    step(V_NONE, "ldu_after_bubble");
    chk_cnt("ldu_cnt_ldu", cnt_ldu, 1);
    chk_cnt("ldu_cnt_stall", cnt_stall, 1);

    // Destination x0 never creates a hazard.
    ex_mem_read = 1'b1; ex_rd = 5'd0;
    step(V_NONE, "ldu_x0");

    // Register-use classes: LUI reads nothing, OP_IMM ignores rs2 field, STORE reads rs2.
    ex_rd = 5'd5; id_inst = lui_rs5;
    step(V_NONE, "lui_no_use");
    id_inst = addi_rs3;
    step(V_NONE, "opimm_no_rs2");
    id_inst = sw_rs2_5;
    step(V_LDU, "store_rs2_hazard");
    ex_mem_read = 1'b0;
    chk_cnt("class_cnt_ldu", cnt_ldu, 2);

    // Taken branch beats load-use.
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_inst = add_x5x5; ex_br_taken = 1'b1;
    step(V_BR, "branch_over_ldu");
    ex_mem_read = 1'b0; ex_br_taken = 1'b0;
    step(V_NONE, "branch_after");
    chk_cnt("branch_cnt_flush", cnt_flush, 1);
    chk_cnt("branch_cnt_ldu", cnt_ldu, 2);
    chk_cnt("branch_cnt_stall", cnt_stall, 2);

    // D-cache miss: detect cycle plus six wait cycles, ready on the last; 7 freezes.
    dc_miss = 1'b1;
    step(V_FRZ, "dc_detect");
    for (int i = 0; i < 5; i++) step(V_FRZ, "dc_wait");
    dc_ready = 1'b1;
    step(V_FRZ, "dc_ready_cycle");
    dc_ready = 1'b0; dc_miss = 1'b0;
    step(V_NONE, "dc_back_to_run");
    chk_cnt("dc_cnt_dcmiss", cnt_dcmiss, 1);
    chk_cnt("dc_cnt_stall", cnt_stall, 9);

    // Dual miss with I-cache fill during DC_WAIT: straight back to RUN.
    ic_miss = 1'b1; dc_miss = 1'b1;
    step(V_FRZ, "dual_detect");
    step(V_FRZ, "dual_dc_wait");
    ic_ready = 1'b1;
    step(V_FRZ, "dual_ic_ready");
    ic_ready = 1'b0;
    step(V_FRZ, "dual_dc_wait2");
    dc_ready = 1'b1;
    step(V_FRZ, "dual_dc_ready");
    dc_ready = 1'b0; dc_miss = 1'b0; ic_miss = 1'b0;
    step(V_NONE, "dual_run");
    chk_cnt("dual_cnt_icmiss", cnt_icmiss, 0);
    chk_cnt("dual_cnt_dcmiss", cnt_dcmiss, 2);
    chk_cnt("dual_cnt_stall", cnt_stall, 14);

    // Dual miss without early fill: DC_WAIT then IC_WAIT; dc_ready ignored there.
    ic_miss = 1'b1; dc_miss = 1'b1;
    step(V_FRZ, "dual2_detect");
    dc_ready = 1'b1;
    step(V_FRZ, "dual2_dc_ready");
    dc_miss = 1'b0;
    step(V_FRZ, "icwait_ignores_dc_ready");
    dc_ready = 1'b0;
    step(V_FRZ, "icwait_hold");
    chk_cnt("dual2_cnt_icmiss", cnt_icmiss, 1);
    chk_cnt("dual2_cnt_dcmiss", cnt_dcmiss, 3);
    chk_cnt("dual2_cnt_stall", cnt_stall, 18);

    // Reset in the middle of IC_WAIT abandons it.
    rst_n = 1'b0;
    step(V_RST, "reset_mid_icwait");
    chk_cnt("rst_cnt_stall", cnt_stall, 0);
    chk_cnt("rst_cnt_icmiss", cnt_icmiss, 0);
    chk_cnt("rst_cnt_dcmiss", cnt_dcmiss, 0);
    chk_cnt("rst_cnt_ldu", cnt_ldu, 0);
    chk_cnt("rst_cnt_flush", cnt_flush, 0);
    rst_n = 1'b1; ic_miss = 1'b0;
    step(V_NONE, "post_reset_run");

    // Saturation: preload all-ones, then stall once more.
    force dut.u_cnt_stall.cnt_q = {CNT_W{1'b1}};
    #1;
    release dut.u_cnt_stall.cnt_q;
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_inst = add_x5x5;
    step(V_LDU, "sat_stall");
    ex_mem_read = 1'b0;
    chk_cnt("sat_cnt_stall", cnt_stall, {CNT_W{1'b1}});
    chk_cnt("sat_cnt_ldu", cnt_ldu, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
